// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative divider.
//   - DIV_FREE/DIV_BYZERO/DIV_ON/DIV_END : 2-bit FSM state encodings
//   - DIV_WIDTH_DEFAULT                  : default operand width
//   - DIV_RESULT_ZERO                    : all-zero result, sliced to 2*WIDTH by users
package div_pkg;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_FREE   = 2'd0;
  localparam div_state_t DIV_BYZERO = 2'd1;
  localparam div_state_t DIV_ON     = 2'd2;
  localparam div_state_t DIV_END    = 2'd3;

  localparam int DIV_WIDTH_DEFAULT = 32;
  localparam int DIV_WIDTH_MAX     = 64;

  // Wide enough for the largest legal WIDTH; users take the low 2*WIDTH bits.
  localparam logic [2*DIV_WIDTH_MAX-1:0] DIV_RESULT_ZERO = '0;

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate.
//   neg_i  : 1 = output -data_i, 0 = pass data_i through
//   data_i : WIDTH-bit input
//   data_o : WIDTH-bit result
// Used both to take operand magnitudes and to restore result signs.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  assign data_o = neg_i ? ((~data_i) + WIDTH'(1)) : data_i;

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring radix-2 signed/unsigned divider.
//   clk, reset      : rising-edge clock, async active-high reset
//   start_i         : request, held by EXE until ready_o
//   annul_i         : flush; aborts any divide, highest priority
//   signed_div_i    : 1 = DIV, 0 = DIVU (sampled with start_i)
//   opdata1_i/2_i   : dividend / divisor (sampled with start_i)
//   result_o        : {remainder, quotient}
//   ready_o         : result valid
// Optional: define DIV_EARLY_OUT_EN to finish immediately when
// |dividend| < |divisor| (same result, shorter latency).
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic               signed_q, signed_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   op1_abs, op2_abs, quo_fix, rem_fix;
  logic [WIDTH:0]     shifted, diff;

  div_sign_fix #(.WIDTH(WIDTH)) u_abs1 (
    .neg_i(signed_div_i & opdata1_i[WIDTH-1]), .data_i(opdata1_i), .data_o(op1_abs));
  div_sign_fix #(.WIDTH(WIDTH)) u_abs2 (
    .neg_i(signed_div_i & opdata2_i[WIDTH-1]), .data_i(opdata2_i), .data_o(op2_abs));
  div_sign_fix #(.WIDTH(WIDTH)) u_fixq (
    .neg_i(signed_q & (sign1_q ^ sign2_q)), .data_i(quo_q), .data_o(quo_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fixr (
    .neg_i(signed_q & sign1_q), .data_i(rem_q), .data_o(rem_fix));

  // Trial subtract; the remainder is always < divisor, so WIDTH+1 bits suffice
  // and the top bit of diff is the borrow.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    signed_d = signed_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      DIV_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (op1_abs < op2_abs) begin
            // Quotient is zero, remainder is the untouched dividend.
            state_d = DIV_END;
            rem_d   = opdata1_i;
            quo_d   = '0;
          end
`endif
          else begin
            state_d  = DIV_ON;
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = op1_abs;
            dvs_d    = op2_abs;
            signed_d = signed_div_i;
            sign1_d  = opdata1_i[WIDTH-1];
            sign2_d  = opdata2_i[WIDTH-1];
          end
        end
      end
      DIV_BYZERO: begin
        rem_d   = '0;
        quo_d   = '0;
        state_d = DIV_END;
      end
      DIV_ON: begin
        if (cnt_q != CW'(WIDTH)) begin
          rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Extra cycle after the last iteration applies the sign correction.
          quo_d   = quo_fix;
          rem_d   = rem_fix;
          state_d = DIV_END;
        end
      end
      DIV_END: begin
        ready_d  = 1'b1;
        result_d = {rem_q, quo_q};
        if (!start_i) begin
          state_d  = DIV_FREE;
          ready_d  = 1'b0;
          result_d = DIV_RESULT_ZERO[2*WIDTH-1:0];
        end
      end
      default: state_d = DIV_FREE;
    endcase

    if (annul_i) begin
      state_d  = DIV_FREE;
      ready_d  = 1'b0;
      result_d = DIV_RESULT_ZERO[2*WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      signed_q <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= DIV_RESULT_ZERO[2*WIDTH-1:0];
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      signed_q <= signed_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised iterative signed/unsigned integer divider for the EXE stage; the next generation of the pipeline's fixed-width divide path.
- Computes quotient and remainder of WIDTH-bit operands in WIDTH+2 cycles.
- Result is packed {remainder, quotient} for a direct HILO write (hi = remainder, lo = quotient).
- EXE holds start_i and raises its stall request until ready_o is asserted.

Parameters:
- WIDTH, 32, operand, quotient and remainder width; legal range 4..64.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start_i  in  1  divide request, held high by EXE until ready_o
- annul_i  in  1  abort current divide (pipeline flush)
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- opdata1_i  in  WIDTH  dividend; sampled with start_i
- opdata2_i  in  WIDTH  divisor; sampled with start_i
- result_o  out  2*WIDTH  {remainder, quotient}
- ready_o  out  1  result valid

Behaviour:
- Reset, asynchronous: state = FREE, result_o = 0, ready_o = 0, counter = 0.
- States: FREE, BYZERO, ON, END. All transitions happen on the clk rising edge.
- FREE:
  - Leaves FREE only when start_i=1 and annul_i=0.
  - Divisor == 0: go to BYZERO.
  - Otherwise: latch |dividend| and |divisor| (absolute value only when signed_div_i=1), latch the two operand sign bits, clear the counter, go to ON.
- BYZERO: result = 0; go to END.
- ON, restoring radix-2:
  - Each cycle: shift the {partial remainder, dividend} register left by 1, trial-subtract the divisor, set the quotient bit to 1 if there is no borrow.
  - counter increments from 0 to WIDTH-1; after the WIDTH-th iteration go to END.
  - Sign fix on exit, signed mode only:
    - quotient is negated if the operand signs differ;
    - remainder is negated if the dividend is negative.
  - Most-negative / -1 wraps: quotient = most-negative, remainder = 0. No trap.
- END:
  - ready_o = 1 and result_o holds the result.
  - Stays in END while start_i = 1.
  - When start_i = 0: go to FREE; ready_o = 0 and result_o = 0 in the next cycle.
- annul_i = 1 in any state: next state is FREE, ready_o = 0, result_o = 0. annul has priority over start_i and over completion.
- Latency, without the optional feature:
  - start sampled in cycle 0; ready_o high in cycle WIDTH+2.
  - Divide by zero: ready_o high in cycle 2.
- start_i arriving while not in FREE is ignored. Operands are not re-sampled until the block returns to FREE.
- Back-to-back divides: a new start is accepted no earlier than one cycle after start_i falls.
- The counter is $clog2(WIDTH)+1 bits wide.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined, FREE additionally checks |dividend| < |divisor| (divisor nonzero).
  - If true: go straight to END with quotient = 0 and remainder = the original signed or unsigned dividend.
  - ready_o is then high in cycle 1.
- When undefined: every nonzero-divisor case takes the full WIDTH+2 cycles.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package div_pkg:
  - 2-bit state encodings DIV_FREE=0, DIV_BYZERO=1, DIV_ON=2, DIV_END=3;
  - DIV_WIDTH_DEFAULT=32;
  - DIV_RESULT_ZERO helper constant.
- One sub-module, div_sign_fix:
  - combinational, parametrised by WIDTH;
  - conditional two's-complement negate, used for operand abs and result correction, so four instances.

Test Plan:
- Unsigned, WIDTH=32: 100 / 7 -> quotient 14, remainder 2; ready_o rises exactly 34 cycles after start.
- Signed: -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed: 7 / -2 -> quotient -3, remainder 1.
- Divide by zero: 5 / 0 -> result_o = 0, ready_o at cycle 2. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- annul_i pulsed at cycle 10 of a divide -> ready_o never rises, state FREE next cycle. An immediate new start 9 / 3 completes with quotient 3, remainder 0.
- Reset asserted mid-ON -> result_o = 0 and ready_o = 0 immediately, without waiting for a clock edge.
- Hold start_i 5 cycles past ready_o -> result stays stable; it clears one cycle after start_i falls.
- WIDTH=8 build: 200 / 3 -> quotient 66, remainder 2, ready at cycle 10.
- With DIV_EARLY_OUT_EN: 3 / 10 -> quotient 0, remainder 3, ready at cycle 1.
